// File: rtl/hwpe_stream_tcdm_rr_arbiter_if.sv
// rtl/hwpe_stream_tcdm_rr_arbiter_if.sv - TCDM request/response interface
// One TCDM port: request channel (req/add/wen/be/data, answered by gnt)
// and the one-cycle-late response channel (r_data/r_valid).
// master drives the request, slave drives gnt and the response.
interface hwpe_stream_intf_tcdm;
    logic        req;
    logic        gnt;
    logic [31:0] add;
    logic        wen;
    logic [3:0]  be;
    logic [31:0] data;
    logic [31:0] r_data;
    logic        r_valid;

    modport master (output req, add, wen, be, data, input gnt, r_data, r_valid);
    modport slave  (input req, add, wen, be, data, output gnt, r_data, r_valid);
endinterface

// File: rtl/hwpe_stream_tcdm_rr_arbiter.sv
// rtl/hwpe_stream_tcdm_rr_arbiter.sv - round-robin TCDM arbiter with response routing
// Shares one TCDM master port between NB_IN_CHAN requesters.
//   clk_i, rst_i  : clock, synchronous active-high reset
//   tcdm_in[]     : requester ports (slave side)
//   tcdm_out      : shared port toward memory (master side)
//   resp_err_o    : sticky, response seen with nothing pending
//   grant_cnt_o   : per-port saturating 16-bit grant counters, port i at [16i+15:16i]
module hwpe_stream_tcdm_rr_arbiter #(
    parameter int unsigned NB_IN_CHAN = 4,
    parameter int unsigned ID_WIDTH   = $clog2(NB_IN_CHAN)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    hwpe_stream_intf_tcdm.slave      tcdm_in [NB_IN_CHAN-1:0],
    hwpe_stream_intf_tcdm.master     tcdm_out,
    output logic                     resp_err_o,
    output logic [NB_IN_CHAN*16-1:0] grant_cnt_o
);

    logic [NB_IN_CHAN-1:0] in_req;
    logic [NB_IN_CHAN-1:0] in_wen;
    logic [31:0]           in_add  [NB_IN_CHAN];
    logic [3:0]            in_be   [NB_IN_CHAN];
    logic [31:0]           in_data [NB_IN_CHAN];
    logic [NB_IN_CHAN-1:0] in_gnt;

    logic [ID_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
    logic                  pend_q, pend_d;
    logic [ID_WIDTH-1:0]   pend_id_q, pend_id_d;
    logic                  resp_err_q, resp_err_d;
    logic [15:0]           grant_cnt_q [NB_IN_CHAN];
    logic [15:0]           grant_cnt_d [NB_IN_CHAN];

    logic [ID_WIDTH-1:0]   winner;
    logic [ID_WIDTH-1:0]   rr_next;
    logic [ID_WIDTH:0]     scan_sum;
    logic [ID_WIDTH-1:0]   scan_idx;
    logic                  found;
    logic                  any_req;
    logic                  hs;

    for (genvar i = 0; i < NB_IN_CHAN; i++) begin : g_port
        assign in_req[i]  = tcdm_in[i].req;
        assign in_wen[i]  = tcdm_in[i].wen;
        assign in_add[i]  = tcdm_in[i].add;
        assign in_be[i]   = tcdm_in[i].be;
        assign in_data[i] = tcdm_in[i].data;
        assign tcdm_in[i].gnt = in_gnt[i];
        // Response goes to the port granted last cycle; r_valid also needs a
        // live pending transaction so stray responses never reach a requester.
        assign tcdm_in[i].r_valid = ~rst_i & pend_q & tcdm_out.r_valid
                                    & (pend_id_q == ID_WIDTH'(i));
        assign tcdm_in[i].r_data  = (~rst_i && pend_id_q == ID_WIDTH'(i))
                                    ? tcdm_out.r_data : 32'd0;
        assign grant_cnt_o[16*i +: 16] = grant_cnt_q[i];
    end

    // Winner depends only on req and rr_ptr_q, never on tcdm_out.gnt.
    always_comb begin
        winner   = '0;
        found    = 1'b0;
        scan_sum = '0;
        scan_idx = '0;
        for (int k = 0; k < NB_IN_CHAN; k++) begin
            scan_sum = {1'b0, rr_ptr_q} + (ID_WIDTH+1)'(k);
            if (scan_sum >= (ID_WIDTH+1)'(NB_IN_CHAN)) begin
                scan_sum = scan_sum - (ID_WIDTH+1)'(NB_IN_CHAN);
            end
            scan_idx = scan_sum[ID_WIDTH-1:0];
            if (!found && in_req[scan_idx]) begin
                found  = 1'b1;
                winner = scan_idx;
            end
        end
    end

    assign any_req = (|in_req) & ~rst_i;
    assign hs      = any_req & tcdm_out.gnt;
    assign rr_next = (winner == ID_WIDTH'(NB_IN_CHAN-1)) ? '0 : winner + ID_WIDTH'(1);

    assign tcdm_out.req  = any_req;
    assign tcdm_out.add  = any_req ? in_add[winner]  : 32'd0;
    assign tcdm_out.wen  = any_req ? in_wen[winner]  : 1'b0;
    assign tcdm_out.be   = any_req ? in_be[winner]   : 4'd0;
    assign tcdm_out.data = any_req ? in_data[winner] : 32'd0;

    always_comb begin
        in_gnt = '0;
        if (any_req) begin
            in_gnt[winner] = tcdm_out.gnt;
        end
    end

    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        pend_d      = 1'b0;
        pend_id_d   = pend_id_q;
        grant_cnt_d = grant_cnt_q;
        resp_err_d  = resp_err_q | (tcdm_out.r_valid & ~pend_q);
        if (hs) begin
            rr_ptr_d  = rr_next;
            pend_d    = 1'b1;
            pend_id_d = winner;
            if (grant_cnt_q[winner] != 16'hFFFF) begin
                grant_cnt_d[winner] = grant_cnt_q[winner] + 16'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr_q   <= '0;
            pend_q     <= 1'b0;
            pend_id_q  <= '0;
            resp_err_q <= 1'b0;
            for (int i = 0; i < NB_IN_CHAN; i++) begin
                grant_cnt_q[i] <= 16'd0;
            end
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            pend_q      <= pend_d;
            pend_id_q   <= pend_id_d;
            resp_err_q  <= resp_err_d;
            grant_cnt_q <= grant_cnt_d;
        end
    end

    assign resp_err_o = resp_err_q;

endmodule

// File: tb/tb_hwpe_stream_tcdm_rr_arbiter.sv
// tb/tb_hwpe_stream_tcdm_rr_arbiter.sv - self-checking bench for hwpe_stream_tcdm_rr_arbiter
module tb_hwpe_stream_tcdm_rr_arbiter;
    localparam int N = 4;

    logic clk;
    logic rst;
    logic resp_err;
    logic [N*16-1:0] grant_cnt;

    logic [N-1:0] req_drv;
    logic [N-1:0] wen_drv;
    logic [31:0]  add_drv  [N];
    logic [3:0]   be_drv   [N];
    logic [31:0]  data_drv [N];
    logic         out_gnt;
    logic         out_r_valid;
    logic [31:0]  out_r_data;

    logic [N-1:0] obs_gnt;
    logic [N-1:0] obs_rvalid;
    logic [31:0]  obs_rdata [N];

    int n_checks = 0;
    int n_pass   = 0;

    int m_rr, m_pend, m_pend_id, m_err;
    int m_cnt [N];

    int          dut_grants[$];
    int          resp_port[$];
    logic [31:0] resp_data[$];

    hwpe_stream_intf_tcdm tcdm_in [N-1:0] ();
    hwpe_stream_intf_tcdm tcdm_out ();

    for (genvar g = 0; g < N; g++) begin : g_drv
        assign tcdm_in[g].req  = req_drv[g];
        assign tcdm_in[g].wen  = wen_drv[g];
        assign tcdm_in[g].add  = add_drv[g];
        assign tcdm_in[g].be   = be_drv[g];
        assign tcdm_in[g].data = data_drv[g];
        assign obs_gnt[g]    = tcdm_in[g].gnt;
        assign obs_rvalid[g] = tcdm_in[g].r_valid;
        assign obs_rdata[g]  = tcdm_in[g].r_data;
    end
    assign tcdm_out.gnt     = out_gnt;
    assign tcdm_out.r_valid = out_r_valid;
    assign tcdm_out.r_data  = out_r_data;

    hwpe_stream_tcdm_rr_arbiter #(.NB_IN_CHAN(N)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .tcdm_in     (tcdm_in),
        .tcdm_out    (tcdm_out),
        .resp_err_o  (resp_err),
        .grant_cnt_o (grant_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    endtask

    // Round-robin rule: first requester at or after the pointer, wrapping.
    function automatic int model_winner();
        for (int k = 0; k < N; k++) begin
            int p;
            p = (m_rr + k) % N;
            if (req_drv[p]) return p;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        int w;
        w = model_winner();
        if (rst) begin
            m_rr = 0; m_pend = 0; m_pend_id = 0; m_err = 0;
            for (int i = 0; i < N; i++) m_cnt[i] = 0;
        end else begin
            if (out_r_valid && m_pend == 0) m_err = 1;
            if (w >= 0 && out_gnt) begin
                m_rr = (w + 1) % N;
                m_pend = 1;
                m_pend_id = w;
                m_cnt[w] = (m_cnt[w] < 65535) ? m_cnt[w] + 1 : 65535;
            end else begin
                m_pend = 0;
            end
        end
    end

    always @(negedge clk) begin
        int w;
        bit act;
        w = model_winner();
        act = !rst && (w >= 0);
        check("out_req",  64'(tcdm_out.req),  64'(act));
        check("out_add",  64'(tcdm_out.add),  act ? 64'(add_drv[w])  : 64'd0);
        check("out_wen",  64'(tcdm_out.wen),  act ? 64'(wen_drv[w])  : 64'd0);
        check("out_be",   64'(tcdm_out.be),   act ? 64'(be_drv[w])   : 64'd0);
        check("out_data", 64'(tcdm_out.data), act ? 64'(data_drv[w]) : 64'd0);
        for (int i = 0; i < N; i++) begin
            check($sformatf("gnt%0d", i), 64'(obs_gnt[i]), 64'(act && w == i && out_gnt));
            check($sformatf("rvalid%0d", i), 64'(obs_rvalid[i]),
                  64'(!rst && m_pend == 1 && m_pend_id == i && out_r_valid));
            check($sformatf("rdata%0d", i), 64'(obs_rdata[i]),
                  (!rst && m_pend_id == i) ? 64'(out_r_data) : 64'd0);
            check($sformatf("cnt%0d", i), 64'(grant_cnt[16*i +: 16]), 64'(m_cnt[i]));
        end
        check("resp_err", 64'(resp_err), 64'(m_err));
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                if (obs_gnt[i] && tcdm_out.req) dut_grants.push_back(i);
                if (obs_rvalid[i]) begin
                    resp_port.push_back(i);
                    resp_data.push_back(obs_rdata[i]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic clear_logs();
        dut_grants.delete();
        resp_port.delete();
        resp_data.delete();
    endtask

    task automatic check_grants(input string nm, input int exp[$]);
        check({nm, "_len"}, 64'(dut_grants.size()), 64'(exp.size()));
        for (int i = 0; i < exp.size(); i++)
            if (i < dut_grants.size()) check(nm, 64'(dut_grants[i]), 64'(exp[i]));
    endtask

    task automatic check_resps(input string nm, input int ports[$], input logic [31:0] datas[$]);
        check({nm, "_len"}, 64'(resp_port.size()), 64'(ports.size()));
        for (int i = 0; i < ports.size(); i++) begin
            if (i < resp_port.size()) begin
                check({nm, "_port"}, 64'(resp_port[i]), 64'(ports[i]));
                check({nm, "_data"}, 64'(resp_data[i]), 64'(datas[i]));
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        req_drv = '0;
        wen_drv = '0;
        out_gnt = 1'b0;
        out_r_valid = 1'b0;
        out_r_data = 32'd0;
        for (int i = 0; i < N; i++) begin
            add_drv[i]  = 32'h1000 + 32'(i) * 32'h10;
            be_drv[i]   = 4'hF;
            data_drv[i] = 32'hD000 + 32'(i);
        end
        repeat (2) tick();
        check("reset_cnt", grant_cnt, 64'd0);
        check("reset_err", 64'(resp_err), 64'd0);
        rst = 1'b0;

        // All ports request continuously.
        clear_logs();
        req_drv = '1;
        out_gnt = 1'b1;
        for (int c = 0; c <= 6; c++) begin
            out_r_valid = (c > 0);
            out_r_data  = 32'h100 + 32'(c);
            if (c == 6) req_drv = '0;
            tick();
        end
        out_r_valid = 1'b0;
        check_grants("all_order", '{0, 1, 2, 3, 0, 1});
        check_resps("all_resp", '{0, 1, 2, 3, 0, 1},
                    '{32'h101, 32'h102, 32'h103, 32'h104, 32'h105, 32'h106});

        // Only port 2 requests, three reads.
        do_reset();
        clear_logs();
        for (int c = 0; c <= 3; c++) begin
            req_drv = (c < 3) ? 4'b0100 : 4'b0000;
            out_r_valid = (c > 0);
            out_r_data  = 32'h200 + 32'(c);
            tick();
        end
        out_r_valid = 1'b0;
        check_grants("p2_order", '{2, 2, 2});
        check_resps("p2_resp", '{2, 2, 2}, '{32'h201, 32'h202, 32'h203});
        check("p2_cnt", 64'(grant_cnt[47:32]), 64'd3);

        // Ports 1 and 3 with pointer at 3, gnt stalled four cycles.
        clear_logs();
        add_drv[1] = 32'hA1;
        add_drv[3] = 32'hA3;
        req_drv = 4'b1010;
        out_gnt = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            check("stall_add", 64'(tcdm_out.add), 64'h0A3);
            tick();
        end
        out_gnt = 1'b1;
        #1;
        check("stall_add", 64'(tcdm_out.add), 64'h0A3);
        tick();
        req_drv = 4'b0010;
        tick();
        req_drv = 4'b0110;
        tick();
        // Pointer sits at 3: port 3 then wrap to port 0.
        req_drv = 4'b1001;
        tick();
        req_drv = 4'b0001;
        tick();
        req_drv = 4'b0000;
        tick();
        check_grants("stall_wrap_order", '{3, 1, 2, 3, 0});

        // Response with nothing pending.
        clear_logs();
        out_gnt = 1'b0;
        tick();
        out_r_valid = 1'b1;
        out_r_data = 32'hBAD;
        #1;
        check("err_no_route", 64'(obs_rvalid), 64'd0);
        tick();
        out_r_valid = 1'b0;
        check("err_set", 64'(resp_err), 64'd1);
        tick();
        check("err_sticky", 64'(resp_err), 64'd1);
        do_reset();
        check("err_cleared", 64'(resp_err), 64'd0);

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 63) == 0);
            req_drv = 4'($urandom);
            wen_drv = 4'($urandom);
            for (int i = 0; i < N; i++) begin
                add_drv[i]  = $urandom;
                be_drv[i]   = 4'($urandom);
                data_drv[i] = $urandom;
            end
            out_gnt     = ($urandom_range(0, 3) != 0);
            out_r_valid = ($urandom_range(0, 2) != 0);
            out_r_data  = $urandom;
            tick();
        end
        rst = 1'b0;

        // Saturation of port 0 counter, then reset right after a handshake.
        do_reset();
        req_drv = 4'b0001;
        out_gnt = 1'b1;
        out_r_valid = 1'b0;
        repeat (65535) tick();
        check("sat_reach", 64'(grant_cnt[15:0]), 64'hFFFF);
        tick();
        check("sat_hold", 64'(grant_cnt[15:0]), 64'hFFFF);
        rst = 1'b1;
        out_r_valid = 1'b1;
        out_r_data = 32'hDEAD;
        #1;
        check("rst_drop_rvalid", 64'(obs_rvalid), 64'd0);
        tick();
        rst = 1'b0;
        req_drv = '0;
        out_r_valid = 1'b0;
        check("rst_cnt_clear", grant_cnt, 64'd0);
        check("rst_err_clear", 64'(resp_err), 64'd0);
        tick();
        check("rst_err_stay", 64'(resp_err), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
